// File: rtl/dkong_pkg.sv
// Shared types for the Donkey Kong work RAM arbiter.
// FSM state encoding and default starvation limit.
package dkong_pkg;

   typedef enum logic [2:0] {
      IDLE,
      STALL,
      HS_ACC,
      HS_CAP,
      DONE
   } arb_state_t;

   localparam int STARVE_MAX_DEF = 8;

endpackage

// File: rtl/dkong_wram_arbiter.sv
// Work RAM port A arbiter: the Z80 has priority, the hiscore engine
// uses idle cycles and stalls the CPU once if it has waited too long.
module dkong_wram_arbiter
   import dkong_pkg::*;
#(
   parameter int AW         = 10,
   parameter int DW         = 8,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic          I_CLK,
   input  logic          I_RESET,
   input  logic          I_CLK_EN_P,
   input  logic          I_CLK_EN_N,
   input  logic          I_CPU_CS,
   input  logic          I_CPU_WE,
   input  logic [AW-1:0] I_CPU_A,
   input  logic [DW-1:0] I_CPU_D,
   output logic [DW-1:0] O_CPU_D,
   output logic          O_CPU_WAIT_n,
   input  logic          I_HS_REQ,
   input  logic          I_HS_WE,
   input  logic [AW-1:0] I_HS_A,
   input  logic [DW-1:0] I_HS_D,
   output logic          O_HS_ACK,
   output logic [DW-1:0] O_HS_D,
   output logic [AW-1:0] O_RAM_A,
   output logic [DW-1:0] O_RAM_D,
   output logic          O_RAM_CE,
   output logic          O_RAM_WE,
   input  logic [DW-1:0] I_RAM_Q
);

   localparam logic [7:0] SMAX = 8'(STARVE_MAX);

   arb_state_t    state;
   logic [7:0]    cnt;
   logic          wait_n;
   logic [DW-1:0] hs_d_q;
   logic          hs_own;

   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         state  <= IDLE;
         cnt    <= '0;
         wait_n <= 1'b1;
         hs_d_q <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (!I_HS_REQ)
                  cnt <= '0;
               else if (!I_CPU_CS)
                  state <= HS_ACC;
               else if (cnt >= SMAX)
                  state <= STALL;
               else if (I_CLK_EN_P)
                  cnt <= cnt + 8'd1;
            end
            STALL: begin
               if (I_CLK_EN_N) begin
                  wait_n <= 1'b0;
                  state  <= HS_ACC;
               end
            end
            HS_ACC: begin
               state <= I_HS_WE ? DONE : HS_CAP;
            end
            HS_CAP: begin
               hs_d_q <= I_RAM_Q;
               state  <= DONE;
            end
            DONE: begin
               wait_n <= 1'b1;
               cnt    <= '0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign hs_own = (state == HS_ACC) || (state == HS_CAP);

   // HS keeps the port through HS_CAP so DONE can refresh CPU read data
   always_comb begin
      O_RAM_A  = I_CPU_A;
      O_RAM_D  = I_CPU_D;
      O_RAM_CE = I_CPU_CS;
      O_RAM_WE = I_CPU_CS & I_CPU_WE;
      if (hs_own) begin
         O_RAM_A  = I_HS_A;
         O_RAM_D  = I_HS_D;
         O_RAM_CE = 1'b1;
         O_RAM_WE = (state == HS_ACC) & I_HS_WE;
      end
      if (I_RESET)
         O_RAM_WE = 1'b0;
   end

   assign O_CPU_D = (!hs_own && I_CPU_CS) ? I_RAM_Q : '0;

   assign O_CPU_WAIT_n = wait_n;

   assign O_HS_ACK = !I_RESET &&
                     (((state == HS_ACC) && I_HS_WE) ||
                      (state == HS_CAP));

   // read data is bypassed in the capture cycle so it is valid with ACK
   assign O_HS_D = I_RESET ? '0 :
                   (state == HS_CAP) ? I_RAM_Q : hs_d_q;

endmodule
